chamber_timer: RTL
==================

CHAMBER_TIMER -- requirements
Module: chamber_timer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-002 Parameter TICK_DIV, default 50000000, SHALL set the number of clk cycles per one-second tick (range 2..2^26).
REQ-003 Parameter FILL_SEC, default 5, SHALL set the fill duration in seconds (8-bit, 0..255).
REQ-004 Parameter DRAIN_SEC, default 7, SHALL set the drain duration in seconds (8-bit, 0..255).
REQ-005 Parameter WAIT_SEC, default 5, SHALL set the pre-open wait duration in seconds (8-bit, 0..255).
REQ-006 The block SHALL have the following ports:
- clk, input, 1 bit: rising-edge clock.
- reset, input, 1 bit: asynchronous, active-low reset.
- filling, input, 1 bit: fill request level from the interlock.
- draining, input, 1 bit: drain request level from the interlock.
- waiting, input, 1 bit: wait request level from the interlock.
- fillFinished, output, 1 bit: one-cycle pulse marking fill complete.
- drainFinished, output, 1 bit: one-cycle pulse marking drain complete.
- waitFinished, output, 1 bit: one-cycle pulse marking wait complete.
- busy, output, 1 bit: high while the FSM is in RUN.
- secondsLeft, output, 8 bits: remaining whole seconds, for the display.
- mode, output, 2 bits: active job; 0 = none, 1 = fill, 2 = drain, 3 = wait.

Function
REQ-007 The FSM SHALL have four states, IDLE, RUN, DONE and RELEASE, all registered.
REQ-008 In IDLE, a sampled request SHALL be selected by priority draining > filling > waiting.
REQ-009 On that edge the block SHALL load mode, set secondsLeft to the matching *_SEC value, clear the prescaler, and go to RUN.
REQ-010 In IDLE with *_SEC = 0, the block SHALL go directly to DONE on the load edge.
REQ-011 In RUN, the prescaler SHALL increment every edge and wrap to 0 at TICK_DIV-1; on the wrap edge secondsLeft SHALL decrement by 1.
REQ-012 When that decrement takes secondsLeft from 1 to 0, the same edge SHALL enter DONE.
REQ-013 The finished pulse SHALL rise after edge DUR*TICK_DIV, where the load edge is edge 0.
REQ-014 In DONE, exactly the finished output selected by mode SHALL be high for exactly one cycle; the next edge SHALL go to RELEASE.
REQ-015 In RELEASE, the block SHALL stay until the selected request is sampled low, then go to IDLE with mode = 0. This prevents retrigger, because the interlock drops its request one edge after sampling the pulse.
REQ-016 While in RUN or DONE, requests other than the selected one SHALL be ignored.
REQ-017 If the selected request is sampled low in RUN (abort), the next state SHALL be IDLE with secondsLeft = 0, mode = 0 and no finished pulse.
REQ-018 If the selected request drops on the same edge as the terminal decrement, completion SHALL take priority: DONE is entered and the pulse is issued.
REQ-019 At most one finished output SHALL be high in any cycle, and never outside DONE.
REQ-020 busy SHALL equal (state == RUN).
REQ-021 secondsLeft SHALL never underflow and SHALL hold its value in DONE and RELEASE.

Reset
REQ-022 Asserting reset low SHALL immediately, without a clock, force: state IDLE, prescaler 0, secondsLeft 0, mode 0, busy 0, all finished outputs 0.
REQ-023 Reset asserted mid-RUN SHALL discard the job and issue no pulse.
REQ-024 After reset deasserts, the first active request SHALL start a fresh full-duration count.

Configuration
REQ-025 When macro CHAMBER_TIMER_FAST_SIM_EN is defined, the effective TICK_DIV SHALL be 4 regardless of the parameter. All other behaviour SHALL be unchanged.
REQ-026 When CHAMBER_TIMER_FAST_SIM_EN is undefined, the parameter TICK_DIV SHALL be used.

Verification (CHAMBER_TIMER_FAST_SIM_EN defined, FILL_SEC=3, DRAIN_SEC=2, WAIT_SEC=0)
REQ-027 Fill: filling=1 sampled at edge 0, held -> secondsLeft 3,2,1,0 at edges 0,4,8,12; fillFinished high only between edges 12 and 13; filling dropped at 13 -> IDLE at edge 14.
REQ-028 Priority: draining=1 and filling=1 sampled together -> mode=2; drainFinished pulses after edge 8; fillFinished stays 0.
REQ-029 Abort: draining dropped after edge 5 -> IDLE at edge 6, secondsLeft 0, no pulse during 40 further cycles.
REQ-030 Zero duration: waiting=1 at edge 0 -> waitFinished high between edges 0 and 1; busy never high.
REQ-031 Async reset: reset low mid-RUN between edges -> all outputs 0 before the next edge; filling still high after release -> full 3-second count restarts.
REQ-032 No retrigger: filling held high for 20 cycles after the pulse -> block stays in RELEASE with exactly one fillFinished pulse.

Source files
------------

// File: rtl/chamber_timer.sv
// Purpose: chamber fill/drain/wait job timer with a 1 s prescaler and a one-cycle finished pulse per job.
// Latency: job loads on the edge a request is sampled; pulse is visible after edge DUR*TICK_DIV (load edge = 0).
// Backpressure: none; the request level is the handshake, and RELEASE holds until the selected request drops.
// Build option: CHAMBER_TIMER_FAST_SIM_EN forces the effective tick divider to 4.
module chamber_timer #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter logic [7:0]  FILL_SEC  = 8'd5,
  parameter logic [7:0]  DRAIN_SEC = 8'd7,
  parameter logic [7:0]  WAIT_SEC  = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       filling,
  input  logic       draining,
  input  logic       waiting,
  output logic       fillFinished,
  output logic       drainFinished,
  output logic       waitFinished,
  output logic       busy,
  output logic [7:0] secondsLeft,
  output logic [1:0] mode
);

`ifdef CHAMBER_TIMER_FAST_SIM_EN
  localparam int unsigned TickDiv = 4;
`else
  localparam int unsigned TickDiv = TICK_DIV;
`endif

  // 26 bits covers the largest divider (2^26), whose terminal count is 2^26-1.
  localparam logic [25:0] PreMax = 26'(TickDiv - 1);

  localparam logic [1:0] MODE_NONE  = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_DRAIN = 2'd2;
  localparam logic [1:0] MODE_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  secs_q, secs_d;
  logic [25:0] pre_q, pre_d;

  logic        job_vld;
  logic [1:0]  job_mode;
  logic [7:0]  job_dur;
  logic        req_sel;

  // Pick the new job by priority drain > fill > wait, with its duration.
  always_comb begin
    job_vld  = 1'b1;
    job_mode = MODE_NONE;
    job_dur  = 8'd0;
    if (draining) begin
      job_mode = MODE_DRAIN;
      job_dur  = DRAIN_SEC;
    end else if (filling) begin
      job_mode = MODE_FILL;
      job_dur  = FILL_SEC;
    end else if (waiting) begin
      job_mode = MODE_WAIT;
      job_dur  = WAIT_SEC;
    end else begin
      job_vld  = 1'b0;
    end
  end

  // Only the request belonging to the active job matters once a job is loaded.
  always_comb begin
    req_sel = 1'b0;
    case (mode_q)
      MODE_FILL:  req_sel = filling;
      MODE_DRAIN: req_sel = draining;
      MODE_WAIT:  req_sel = waiting;
      default:    req_sel = 1'b0;
    endcase
  end

  // Next-state logic; a terminal decrement beats a simultaneous request drop.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    secs_d  = secs_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE: begin
        if (job_vld) begin
          mode_d  = job_mode;
          secs_d  = job_dur;
          pre_d   = 26'd0;
          state_d = (job_dur == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pre_q == PreMax && secs_q <= 8'd1) begin
          pre_d   = 26'd0;
          secs_d  = 8'd0;
          state_d = DONE;
        end else if (!req_sel) begin
          pre_d   = 26'd0;
          secs_d  = 8'd0;
          mode_d  = MODE_NONE;
          state_d = IDLE;
        end else if (pre_q == PreMax) begin
          pre_d   = 26'd0;
          secs_d  = secs_q - 8'd1;
        end else begin
          pre_d   = pre_q + 26'd1;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_sel) begin
          mode_d  = MODE_NONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        mode_d  = MODE_NONE;
        secs_d  = 8'd0;
        pre_d   = 26'd0;
      end
    endcase
  end

  // State, job and counter registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_NONE;
      secs_q  <= 8'd0;
      pre_q   <= 26'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      secs_q  <= secs_d;
      pre_q   <= pre_d;
    end
  end

  // Outputs decode straight from registers, so reset clears them immediately.
  assign busy          = (state_q == RUN);
  assign fillFinished  = (state_q == DONE) && (mode_q == MODE_FILL);
  assign drainFinished = (state_q == DONE) && (mode_q == MODE_DRAIN);
  assign waitFinished  = (state_q == DONE) && (mode_q == MODE_WAIT);
  assign secondsLeft   = secs_q;
  assign mode          = mode_q;

endmodule
